mem_arbiter: RTL

Parametrised SRAM arbiter that generalises the CPU/video shared-bus scheme into a synchronous, multi-channel, request/acknowledge controller. It serves one CPU port, `VCH` independent video read channels and the ROM loader over one external asynchronous SRAM. Every access is a fixed two-cycle slot. It sits between the CPU/video/loader logic and the board SRAM pins, in place of the video-column-timed bus switch.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-cycle-slot SRAM arbiter that shares one asynchronous SRAM between a CPU port,
// VCH video read channels and a ROM loader. All SRAM-facing outputs come straight from flops.
module mem_arbiter #(
  parameter int AW          = 21,
  parameter int DW          = 8,
  parameter int VCH         = 2,
  parameter int CPU_MAXWAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loader_act,
  input  logic [AW-1:0]     loader_a,
  input  logic [DW-1:0]     loader_d,
  input  logic              loader_wr,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [AW-1:0]     cpu_a,
  input  logic [DW-1:0]     cpu_di,
  output logic [DW-1:0]     cpu_do,
  output logic              cpu_ack,
  input  logic [VCH-1:0]    vid_req,
  input  logic [VCH*AW-1:0] vid_a,
  output logic [DW-1:0]     vid_do,
  output logic [VCH-1:0]    vid_valid,
  output logic [AW-1:0]     ma,
  output logic [DW-1:0]     md_o,
  input  logic [DW-1:0]     md_i,
  output logic              md_oe,
  output logic              mrd_n,
  output logic              mwr_n
);

  localparam int CW = (VCH > 1) ? $clog2(VCH) : 1;
  localparam int SW = (CPU_MAXWAIT > 0) ? $clog2(CPU_MAXWAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, LOAD} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   rr_ptr;
  logic [SW-1:0]   starve;
  logic            slot_cpu;
  logic            slot_wr;
  logic [CW-1:0]   slot_ch;

  logic            cpu_elig;
  logic [VCH-1:0]  vid_elig;
  logic            vid_any;
  logic [CW-1:0]   vsel;
  logic            found;
  int unsigned     idx;
  logic            grant_cpu;
  logic            grant_vid;
  logic            grant_wr;
  logic [AW-1:0]   grant_a;

  always_comb begin
    cpu_elig = cpu_req;
    vid_elig = vid_req;
    // The requester of the slot in ACC2 is still holding its request; it must not win its own ack cycle.
    if (state == ACC2) begin
      if (slot_cpu) cpu_elig = 1'b0;
      else          vid_elig[slot_ch] = 1'b0;
    end
    vid_any = |vid_elig;

    vsel  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < VCH; k++) begin
      idx = ({{(32-CW){1'b0}}, rr_ptr} + k) % VCH;
      if (!found && vid_elig[CW'(idx)]) begin
        found = 1'b1;
        vsel  = CW'(idx);
      end
    end

    state_next = state;
    grant_cpu  = 1'b0;
    grant_vid  = 1'b0;
    case (state)
      IDLE, ACC2: begin
        state_next = IDLE;
        if (loader_act)                                     state_next = LOAD;
        else if (cpu_elig && (starve >= SW'(CPU_MAXWAIT)))  grant_cpu  = 1'b1;
        else if (vid_any)                                   grant_vid  = 1'b1;
        else if (cpu_elig)                                  grant_cpu  = 1'b1;
        if (grant_cpu || grant_vid) state_next = ACC1;
      end
      ACC1:    state_next = ACC2;
      LOAD:    state_next = loader_act ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase

    grant_wr = grant_cpu & cpu_wr;
    grant_a  = grant_cpu ? cpu_a : vid_a[int'(vsel)*AW +: AW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      starve    <= '0;
      slot_cpu  <= 1'b0;
      slot_wr   <= 1'b0;
      slot_ch   <= '0;
      ma        <= '0;
      md_o      <= '0;
      md_oe     <= 1'b0;
      mrd_n     <= 1'b1;
      mwr_n     <= 1'b1;
      cpu_ack   <= 1'b0;
      vid_valid <= '0;
      cpu_do    <= '0;
      vid_do    <= '0;
    end else begin
      state     <= state_next;
      cpu_ack   <= 1'b0;
      vid_valid <= '0;

      if (state == ACC2) begin
        if (slot_cpu) begin
          cpu_ack <= 1'b1;
          if (!slot_wr) cpu_do <= md_i;
        end else begin
          vid_valid <= VCH'(1) << slot_ch;
          vid_do    <= md_i;
        end
      end

      if (grant_cpu)
        starve <= '0;
      else if (grant_vid && cpu_req && (starve < SW'(CPU_MAXWAIT)))
        starve <= starve + 1'b1;

      if (grant_vid)
        rr_ptr <= (vsel == CW'(VCH - 1)) ? '0 : vsel + 1'b1;

      case (state_next)
        ACC1: begin
          slot_cpu <= grant_cpu;
          slot_wr  <= grant_wr;
          slot_ch  <= vsel;
          ma       <= grant_a;
          md_o     <= cpu_di;
          md_oe    <= grant_wr;
          mrd_n    <= grant_wr;
          mwr_n    <= 1'b1;
        end
        ACC2: mwr_n <= ~slot_wr;
        LOAD: begin
          ma    <= loader_a;
          md_o  <= loader_d;
          md_oe <= loader_wr;
          mwr_n <= ~loader_wr;
          mrd_n <= 1'b1;
        end
        default: begin
          md_oe <= 1'b0;
          mrd_n <= 1'b1;
          mwr_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
